// File: rtl/zbt_arbiter_pkg.sv
// Shared types and constants for the ZBT SRAM time-slot arbiter.
// Slot codes, clear-engine states, slot grants and the write-FIFO entry layout.
package zbt_arbiter_pkg;

    localparam int ZBT_AW = 19;
    localparam int ZBT_DW = 36;
    localparam int WR_ENTRY_W = ZBT_AW + ZBT_DW;

    localparam logic [1:0] SLOT_RD = 2'd0;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        GRANT_READ  = 2'd0,
        GRANT_FIFO  = 2'd1,
        GRANT_CLEAR = 2'd2,
        GRANT_IDLE  = 2'd3
    } grant_t;

    typedef struct packed {
        logic [ZBT_AW-1:0] addr;
        logic [ZBT_DW-1:0] data;
    } wr_entry_t;

    // Slot 0 always reads; write slots prefer queued scanner writes over the sweep.
    function automatic grant_t slot_grant(input logic [1:0] slot,
                                          input logic       fifo_ready,
                                          input logic       clr_active);
        grant_t g;
        if (slot == SLOT_RD)
            g = GRANT_READ;
        else if (fifo_ready)
            g = GRANT_FIFO;
        else if (clr_active)
            g = GRANT_CLEAR;
        else
            g = GRANT_IDLE;
        return g;
    endfunction

endpackage

// File: rtl/zbt_arbiter_wr_fifo.sv
// Synchronous FIFO holding scanner writes until a write slot is free.
// Full, empty and count all reflect occupancy at the start of the cycle.
module zbt_arbiter_wr_fifo
    import zbt_arbiter_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  wr_entry_t   push_entry,
    input  logic        pop,
    output wr_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        dropped
);
    localparam int DEPTH = 1 << AW;

    wr_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // A push seen while full is lost even if a pop frees a place in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dropped = push && full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zbt_arbiter.sv
// Time-slot scheduler sharing one ZBT SRAM port between display reads,
// scanner writes and the frame-clear sweep; slots follow hcount[1:0].
//
//  state     | meaning
//  CLR_IDLE  | no sweep pending, clear_busy low
//  CLR_SWEEP | writing CLEAR_DATA from clr_addr up to CLEAR_LAST in unclaimed write slots
module zbt_arbiter
    import zbt_arbiter_pkg::*;
#(
    parameter int                READ_LATENCY = 2,
    parameter int                FIFO_AW      = 4,
    parameter logic [ZBT_AW-1:0] CLEAR_LAST   = 19'h3FFFF,
    parameter logic [ZBT_DW-1:0] CLEAR_DATA   = 36'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [ZBT_AW-1:0] disp_addr,
    output logic [ZBT_DW-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ZBT_AW-1:0] wr_addr,
    input  logic [ZBT_DW-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              mem_we,
    output logic [ZBT_AW-1:0] mem_addr,
    output logic [ZBT_DW-1:0] mem_write_data,
    input  logic [ZBT_DW-1:0] mem_read_data
);

    grant_t            grant;
    clr_state_t        clr_state;
    clr_state_t        clr_state_nx;
    logic [ZBT_AW-1:0] clr_addr;
    logic [ZBT_AW-1:0] clr_addr_nx;

    wr_entry_t         push_entry;
    wr_entry_t         fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_dropped;
    logic [FIFO_AW:0]  fifo_count;

    logic [READ_LATENCY:0] rd_tag;
    logic                  unused_bits;

    assign unused_bits = ^{hcount[10:2], fifo_count};

    assign push_entry = {wr_addr, wr_data};
    assign grant      = slot_grant(hcount[1:0], !fifo_empty, clr_state == CLR_SWEEP);
    assign wr_full    = fifo_full;
    assign clear_busy = (clr_state == CLR_SWEEP);

    zbt_arbiter_wr_fifo #(
        .AW(FIFO_AW)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (wr_req),
        .push_entry (push_entry),
        .pop        (grant == GRANT_FIFO),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .dropped    (fifo_dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_state <= CLR_IDLE;
            clr_addr  <= '0;
        end else begin
            clr_state <= clr_state_nx;
            clr_addr  <= clr_addr_nx;
        end
    end

    // clr_addr only advances on slots the sweep actually won, so FIFO writes
    // interleave without skipping any clear address.
    always_comb begin
        clr_state_nx = clr_state;
        clr_addr_nx  = clr_addr;
        case (clr_state)
            CLR_IDLE: begin
                if (clear_start) begin
                    clr_state_nx = CLR_SWEEP;
                    clr_addr_nx  = '0;
                end
            end
            CLR_SWEEP: begin
                if (grant == GRANT_CLEAR) begin
                    if (clr_addr == CLEAR_LAST)
                        clr_state_nx = CLR_IDLE;
                    else
                        clr_addr_nx = clr_addr + ZBT_AW'(1);
                end
            end
            default: clr_state_nx = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            case (grant)
                GRANT_READ: begin
                    mem_we   <= 1'b0;
                    mem_addr <= disp_addr;
                end
                GRANT_FIFO: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= fifo_head.addr;
                    mem_write_data <= fifo_head.data;
                end
                GRANT_CLEAR: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= clr_addr;
                    mem_write_data <= CLEAR_DATA;
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

    // One tag per read slot; the tag reaches the top bit when the SRAM word is on mem_read_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag     <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_tag     <= {rd_tag[READ_LATENCY-1:0], grant == GRANT_READ};
            disp_valid <= rd_tag[READ_LATENCY];
            if (rd_tag[READ_LATENCY])
                disp_data <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            wr_overflow <= 1'b0;
        else if (fifo_dropped)
            wr_overflow <= 1'b1;
        else if (clear_start)
            wr_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_zbt_arbiter.sv
// Bench for zbt_arbiter: a queue-based reference model predicts every SRAM
// transaction and display return; a negedge monitor compares them.
module tb_zbt_arbiter;

    localparam int          RL       = 2;
    localparam int          DEPTH    = 16;
    localparam logic [18:0] CLR_LAST = 19'h0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [18:0] disp_addr = '0;
    logic [35:0] disp_data;
    logic        disp_valid;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [35:0] wr_data = '0;
    logic        wr_full;
    logic        wr_overflow;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [35:0] mem_write_data;
    logic [35:0] mem_read_data = '0;

    always #5 clk = ~clk;

    zbt_arbiter #(
        .READ_LATENCY (RL),
        .FIFO_AW      (4),
        .CLEAR_LAST   (CLR_LAST),
        .CLEAR_DATA   (36'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hcount         (hcount),
        .disp_addr      (disp_addr),
        .disp_data      (disp_data),
        .disp_valid     (disp_valid),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .wr_overflow    (wr_overflow),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // SRAM stand-in: returns the address as data, two cycles after mem_addr is presented.
    logic [18:0] rd_pipe = '0;
    always @(posedge clk) begin
        rd_pipe       <= mem_addr;
        mem_read_data <= {17'd0, rd_pipe};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction queues driven by the slot rules.
    logic [54:0] m_fifo[$];
    logic [54:0] exp_wr[$];
    logic [18:0] exp_rd_addr[$];
    int          exp_rd_cyc[$];
    bit          m_busy = 0;
    int          m_clr = 0;
    bit          m_ovf = 0;
    bit          last_rd = 0;
    logic [18:0] last_rd_addr = '0;
    int          cyc = 0;
    int          n0;
    bit          busy0;

    always @(posedge clk) begin
        if (reset) begin
            m_fifo.delete();
            exp_wr.delete();
            exp_rd_addr.delete();
            exp_rd_cyc.delete();
            m_busy  = 0;
            m_clr   = 0;
            m_ovf   = 0;
            last_rd = 0;
        end else begin
            n0      = m_fifo.size();
            busy0   = m_busy;
            last_rd = 0;
            if (hcount[1:0] == 2'd0) begin
                exp_rd_addr.push_back(disp_addr);
                exp_rd_cyc.push_back(cyc);
                last_rd      = 1;
                last_rd_addr = disp_addr;
            end else if (n0 > 0) begin
                exp_wr.push_back(m_fifo.pop_front());
            end else if (busy0) begin
                exp_wr.push_back({m_clr[18:0], 36'h0});
                if (m_clr == int'(CLR_LAST)) m_busy = 0;
                else m_clr++;
            end
            if (wr_req) begin
                if (n0 == DEPTH) m_ovf = 1;
                else m_fifo.push_back({wr_addr, wr_data});
            end
            if (clear_start) begin
                if (!busy0) begin
                    m_busy = 1;
                    m_clr  = 0;
                end
                if (!(wr_req && n0 == DEPTH)) m_ovf = 0;
            end
        end
        cyc++;
    end

    logic [54:0] e_wr;
    logic [18:0] e_rd;
    int          e_cyc;

    always @(negedge clk) begin
        check("clear_busy", clear_busy, m_busy);
        check("wr_full", wr_full, m_fifo.size() == DEPTH);
        check("wr_overflow", wr_overflow, m_ovf);
        if (last_rd) begin
            check("rd_slot_we", mem_we, 1'b0);
            check("rd_slot_addr", mem_addr, last_rd_addr);
        end
        if (mem_we) begin
            n_we++;
            check("write_expected", exp_wr.size() != 0, 1'b1);
            if (exp_wr.size() != 0) begin
                e_wr = exp_wr.pop_front();
                check("mem_write", {mem_addr, mem_write_data}, e_wr);
            end
        end
        if (disp_valid) begin
            check("read_expected", exp_rd_addr.size() != 0, 1'b1);
            if (exp_rd_addr.size() != 0) begin
                e_rd  = exp_rd_addr.pop_front();
                e_cyc = exp_rd_cyc.pop_front();
                check("disp_data", disp_data, {17'd0, e_rd});
                check("rd_latency", cyc - e_cyc, RL + 2);
            end
        end
    end

    bit hold_h = 0;

    task automatic step();
        @(negedge clk);
        if (!hold_h) hcount = hcount + 11'd1;
        wr_req      = 1'b0;
        clear_start = 1'b0;
        disp_addr   = 19'($urandom);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_clear_done(input string name);
        int k = 0;
        while (clear_busy && k < 200) begin
            step();
            k++;
        end
        check(name, clear_busy, 1'b0);
    endtask

    task automatic push_rand();
        wr_req  = 1'b1;
        wr_addr = 19'($urandom);
        wr_data = {4'($urandom), 32'($urandom)};
    endtask

    int we_before;

    initial begin
        steps(3);
        reset = 1'b0;

        // single read at hcount=4 returning its own address
        step();
        hcount = 11'd3;
        step();
        disp_addr = 19'h00123;
        steps(8);

        // five consecutive scanner writes
        for (int i = 0; i < 5; i++) begin
            step();
            wr_req  = 1'b1;
            wr_addr = {1'b0, 10'd7, 8'(i)};
            wr_data = {4'($urandom), 32'($urandom)};
        end
        steps(12);

        // overflow with hcount frozen in the read slot
        hold_h = 1;
        hcount = 11'd4;
        for (int i = 0; i < 20; i++) begin
            step();
            push_rand();
        end
        step();
        check("t4_full", wr_full, 1'b1);
        check("t4_overflow", wr_overflow, 1'b1);
        hold_h = 0;
        steps(40);

        // frame clear with a second start mid-sweep
        step();
        we_before   = n_we;
        clear_start = 1'b1;
        step();
        check("t5_overflow_cleared", wr_overflow, 1'b0);
        check("t5_busy", clear_busy, 1'b1);
        steps(5);
        clear_start = 1'b1;
        wait_clear_done("t5_clear_done");
        step();
        check("t5_clear_writes", n_we - we_before, 16);

        // scanner writes arriving during a sweep
        step();
        clear_start = 1'b1;
        steps(6);
        push_rand();
        step();
        push_rand();
        wait_clear_done("t6_clear_done");
        steps(4);

        // reset mid-sweep with the FIFO holding entries
        step();
        clear_start = 1'b1;
        steps(3);
        hold_h = 1;
        hcount = 11'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            push_rand();
        end
        step();
        reset = 1'b1;
        steps(3);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_mem_addr", mem_addr, 19'd0);
        check("t1_mem_write_data", mem_write_data, 36'd0);
        check("t1_disp_valid", disp_valid, 1'b0);
        check("t1_disp_data", disp_data, 36'd0);
        check("t1_wr_full", wr_full, 1'b0);
        check("t1_wr_overflow", wr_overflow, 1'b0);
        check("t1_clear_busy", clear_busy, 1'b0);
        reset  = 1'b0;
        hold_h = 0;
        steps(20);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            step();
            if ($urandom_range(0, 9) == 0) hcount = 11'($urandom);
            if ($urandom_range(0, 9) < 4) push_rand();
            else if ($urandom_range(0, 49) == 0) clear_start = 1'b1;
        end

        // drain, then park in a write slot so no read is in flight
        steps(100);
        hold_h = 1;
        hcount = 11'd1;
        steps(10);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_reads", exp_rd_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
